// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the memory transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first request after last_i.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0]   w_start;
    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;
    int                 w_sum;

    always_comb begin
        w_start = (int'(last_i) >= NUM_REQ - 1) ? '0 : last_i + 1'b1;
    end

    // Rotate so the requester just after last_i sits at bit 0.
    assign w_rot = NUM_REQ'({req_i, req_i} >> w_start);

    always_comb begin
        w_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_sum = int'(w_start) + int'(w_off);
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        idx_o = IDX_W'(w_sum);
    end

    assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin sharing of one memory_ctrl transaction port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            w_en_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] w_data_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         r_data_o,
    output logic                          busy_o,
    output logic                          ctrl_do_tran_o,
    output logic                          ctrl_w_en_o,
    output logic [ADDR_WIDTH-1:0]         ctrl_addr_o,
    output logic [DATA_WIDTH-1:0]         ctrl_w_data_o,
    input  logic [DATA_WIDTH-1:0]         ctrl_r_data_i,
    input  logic                          ctrl_tran_done_i
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_e                 state_q,   state_d;
    logic [IDX_W-1:0]       last_q,    last_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [NUM_REQ-1:0]     grant_q,   grant_d;
    logic [NUM_REQ-1:0]     done_q,    done_d;
    logic [DATA_WIDTH-1:0]  r_data_q,  r_data_d;
    logic                   busy_q,    busy_d;
    logic                   do_tran_q, do_tran_d;
    logic                   w_en_q,    w_en_d;
    logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;

    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_sel_wen;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i   (req_i),
        .last_i  (last_q),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(w_arb_idx) == k) begin
                w_sel_wen   = w_en_i[k];
                w_sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = w_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        done_d    = '0;
        r_data_d  = r_data_q;
        do_tran_d = 1'b0;
        w_en_d    = w_en_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (w_arb_valid) begin
                    idx_d     = w_arb_idx;
                    grant_d   = NUM_REQ'(1) << w_arb_idx;
                    w_en_d    = w_sel_wen;
                    addr_d    = w_sel_addr;
                    wdata_d   = w_sel_wdata;
                    do_tran_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Writes leave the last read result visible to requesters.
                if (ctrl_tran_done_i) begin
                    if (!w_en_q) begin
                        r_data_d = ctrl_r_data_i;
                    end
                    done_d  = NUM_REQ'(1) << idx_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = idx_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            idx_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            r_data_q  <= '0;
            busy_q    <= 1'b0;
            do_tran_q <= 1'b0;
            w_en_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            r_data_q  <= r_data_d;
            busy_q    <= busy_d;
            do_tran_q <= do_tran_d;
            w_en_q    <= w_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign r_data_o       = r_data_q;
    assign busy_o         = busy_q;
    assign ctrl_do_tran_o = do_tran_q;
    assign ctrl_w_en_o    = w_en_q;
    assign ctrl_addr_o    = addr_q;
    assign ctrl_w_data_o  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomized bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int DW = 256;
    localparam int AW = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_i;
    logic [N-1:0]    w_en_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] w_data_i;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    done_o;
    logic [DW-1:0]   r_data_o;
    logic            busy_o;
    logic            ctrl_do_tran_o;
    logic            ctrl_w_en_o;
    logic [AW-1:0]   ctrl_addr_o;
    logic [DW-1:0]   ctrl_w_data_o;
    logic [DW-1:0]   ctrl_r_data_i;
    logic            ctrl_tran_done_i;

    mem_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_i            (req_i),
        .w_en_i           (w_en_i),
        .addr_i           (addr_i),
        .w_data_i         (w_data_i),
        .grant_o          (grant_o),
        .done_o           (done_o),
        .r_data_o         (r_data_o),
        .busy_o           (busy_o),
        .ctrl_do_tran_o   (ctrl_do_tran_o),
        .ctrl_w_en_o      (ctrl_w_en_o),
        .ctrl_addr_o      (ctrl_addr_o),
        .ctrl_w_data_o    (ctrl_w_data_o),
        .ctrl_r_data_i    (ctrl_r_data_i),
        .ctrl_tran_done_i (ctrl_tran_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    // Environment knobs: mode 0 random requesters, 1 directed, 2 all-hold.
    int            mode;
    bit            churn;
    int            strays;
    int            fixed_lat;
    int            hold_rst;
    bit            use_man_rdata;
    logic [DW-1:0] man_rdata;
    logic [N-1:0]  man_req;
    logic [N-1:0]  man_wen;
    logic [AW-1:0] man_addr [N];
    logic [DW-1:0] man_wdata [N];

    // Transaction-level reference state.
    bit            m_inflight;
    int            m_issue_at;
    int            m_done_at;
    int            m_eval_from;
    int            c_done_at;
    int            m_owner;
    int            m_last;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_rdata_next;

    logic [N-1:0]  obs_grants [$];
    logic [AW-1:0] obs_addrs [$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_inflight  = 1'b0;
        m_issue_at  = -1;
        m_done_at   = -1;
        c_done_at   = -1;
        m_eval_from = 0;
        m_last      = N - 1;
        m_owner     = 0;
        m_wen       = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_rdata     = '0;
    endtask

    task automatic env_drive();
        for (int k = 0; k < N; k++) begin
            if (done_o[k]) man_req[k] = 1'b0;
        end
        case (mode)
            0: begin
                for (int k = 0; k < N; k++) begin
                    if (done_o[k]) req_i[k] = 1'b0;
                    else if (!req_i[k] && $urandom_range(2) == 0) req_i[k] = 1'b1;
                end
            end
            2:       req_i = ~done_o;
            default: req_i = man_req;
        endcase
        for (int k = 0; k < N; k++) begin
            if (churn) begin
                w_en_i[k]              = 1'($urandom_range(1));
                addr_i[k*AW +: AW]     = AW'($urandom);
                w_data_i[k*DW +: DW]   = rand_word();
            end else begin
                w_en_i[k]              = man_wen[k];
                addr_i[k*AW +: AW]     = man_addr[k];
                w_data_i[k*DW +: DW]   = man_wdata[k];
            end
        end
        ctrl_tran_done_i = 1'b0;
        if (c_done_at == cyc) begin
            ctrl_tran_done_i = 1'b1;
            ctrl_r_data_i    = use_man_rdata ? man_rdata : rand_word();
            c_done_at        = -1;
            if (m_inflight) begin
                m_done_at    = cyc + 1;
                m_rdata_next = ctrl_r_data_i;
            end
        end else if (strays > 0 && c_done_at < 0 && !reset && $urandom_range(strays - 1) == 0) begin
            ctrl_tran_done_i = 1'b1;
            ctrl_r_data_i    = rand_word();
        end
        if (hold_rst > 0) begin
            hold_rst--;
            if (hold_rst == 0) reset = 1'b0;
        end
        // Arbitration rule: first requester found scanning upward from last+1.
        if (!reset && !m_inflight && cyc >= m_eval_from && (|req_i)) begin
            int w;
            w = -1;
            for (int off = 1; off <= N; off++) begin
                if (w < 0 && req_i[(m_last + off) % N]) w = (m_last + off) % N;
            end
            m_owner    = w;
            m_wen      = w_en_i[w];
            m_addr     = addr_i[w*AW +: AW];
            m_wdata    = w_data_i[w*DW +: DW];
            m_inflight = 1'b1;
            m_issue_at = cyc + 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == m_done_at && !m_wen) m_rdata = m_rdata_next;
        check("do_tran",     ctrl_do_tran_o, (cyc == m_issue_at));
        check("done",        done_o, (cyc == m_done_at) ? onehot(m_owner) : '0);
        check("busy",        busy_o, m_inflight);
        check("grant",       grant_o, m_inflight ? onehot(m_owner) : '0);
        check("ctrl_w_en",   ctrl_w_en_o, m_wen);
        check("ctrl_addr",   ctrl_addr_o, m_addr);
        check("ctrl_w_data", ctrl_w_data_o, m_wdata);
        check("r_data",      r_data_o, m_rdata);
        if (ctrl_do_tran_o && !reset) begin
            obs_grants.push_back(grant_o);
            obs_addrs.push_back(ctrl_addr_o);
            c_done_at = cyc + ((fixed_lat > 0) ? fixed_lat : $urandom_range(5, 1));
        end
        if (cyc == m_done_at) begin
            m_inflight  = 1'b0;
            m_last      = m_owner;
            m_eval_from = cyc + 1;
            m_done_at   = -1;
            m_issue_at  = -1;
        end
        env_drive();
    endtask

    task automatic run_until_quiet(input int budget);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while ((m_inflight || req_i != '0 || busy_o) && k < budget);
        check("quiet_timeout", (m_inflight || req_i != '0 || busy_o), 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},   grant_o, '0);
        check({tag, "_done"},    done_o, '0);
        check({tag, "_r_data"},  r_data_o, '0);
        check({tag, "_busy"},    busy_o, '0);
        check({tag, "_do_tran"}, ctrl_do_tran_o, '0);
        check({tag, "_w_en"},    ctrl_w_en_o, '0);
        check({tag, "_addr"},    ctrl_addr_o, '0);
        check({tag, "_w_data"},  ctrl_w_data_o, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        n_checks = 0;  n_errors = 0;  cyc = 0;
        mode = 1;  churn = 1'b0;  strays = 0;  fixed_lat = 3;  hold_rst = 0;
        use_man_rdata = 1'b0;  man_rdata = '0;  man_req = '0;  man_wen = '0;
        for (int i = 0; i < N; i++) begin
            man_addr[i]  = '0;
            man_wdata[i] = '0;
        end
        req_i = '0;  w_en_i = '0;  addr_i = '0;  w_data_i = '0;
        ctrl_r_data_i = '0;  ctrl_tran_done_i = 1'b0;
        model_reset();

        reset = 1'b0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        hold_rst = 3;
        repeat (4) cycle();

        // Single read from requester 1.
        obs_grants.delete();  obs_addrs.delete();
        man_addr[1] = 16'h0040;  man_req = 3'b010;
        use_man_rdata = 1'b1;  man_rdata = {32{8'hA5}};
        run_until_quiet(40);
        check("rd_grant", (obs_grants.size() > 0) ? obs_grants[0] : '0, 3'b010);
        check("rd_addr",  (obs_addrs.size() > 0) ? obs_addrs[0] : '0, 16'h0040);
        check("rd_data",  r_data_o, {32{8'hA5}});

        // Write from requester 2; read data must survive it.
        obs_grants.delete();  obs_addrs.delete();
        use_man_rdata = 1'b0;
        man_wen[2] = 1'b1;  man_addr[2] = 16'h1234;  man_wdata[2] = {8{32'hDEADBEEF}};
        man_req = 3'b100;
        run_until_quiet(40);
        check("wr_grant", (obs_grants.size() > 0) ? obs_grants[0] : '0, 3'b100);
        check("wr_addr",  (obs_addrs.size() > 0) ? obs_addrs[0] : '0, 16'h1234);
        check("wr_keeps_rdata", r_data_o, {32{8'hA5}});

        // All requesters held: grants must rotate 0,1,2,0,1,2.
        obs_grants.delete();
        mode = 2;  churn = 1'b1;  strays = 2;  fixed_lat = 0;
        k = 0;
        while (obs_grants.size() < 6 && k < 300) begin
            cycle();
            k++;
        end
        check("fair_timeout", (obs_grants.size() < 6), 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("fair_order", (obs_grants.size() > i) ? obs_grants[i] : '0, onehot(i % 3));
        end
        man_req = req_i;  mode = 1;
        run_until_quiet(200);

        // Input churn during a requester-0 transaction.
        strays = 0;  fixed_lat = 4;  man_req = 3'b001;
        run_until_quiet(40);

        // Stray tran_done pulses while idle.
        churn = 1'b0;  strays = 1;
        repeat (12) cycle();

        // Randomized traffic.
        mode = 0;  churn = 1'b1;  strays = 6;  fixed_lat = 0;
        repeat (1500) cycle();
        mode = 1;  man_req = req_i;
        run_until_quiet(300);

        // Reset while waiting on the controller.
        strays = 0;  fixed_lat = 4;  man_req = 3'b001;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!(m_inflight && m_issue_at > 0 && cyc > m_issue_at && m_done_at < 0) && k < 30);
        check("wait_busy", busy_o, 1'b1);
        reset = 1'b1;
        ctrl_tran_done_i = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        obs_grants.delete();
        man_req = 3'b111;  hold_rst = 2;
        k = 0;
        while (obs_grants.size() < 1 && k < 30) begin
            cycle();
            k++;
        end
        check("rst_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : '0, 3'b001);
        run_until_quiet(200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
